// File: rtl/score_sequencer.sv
// rtl/score_sequencer.sv - Mastermind guess sequencer driving the peg-compare datapath
// Optional guess limit: define SCORE_SEQ_LIMIT_EN; otherwise guesses are unlimited and lose stays 0.
module score_sequencer #(
    parameter int MAX_GUESSES = 10
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        code_load,
    input  logic [11:0] code_in,
    input  logic        guess_valid,
    output logic        guess_ready,
    input  logic [11:0] guess_in,
    output logic        cmp_resetn,
    output logic        cmp_en,
    output logic [1:0]  cmp_idx,
    output logic [2:0]  cmp_code,
    output logic [11:0] cmp_guess,
    input  logic [2:0]  cmp_red,
    input  logic [2:0]  cmp_white,
    output logic        result_valid,
    output logic [2:0]  score_red,
    output logic [2:0]  score_white,
    output logic [3:0]  guess_count,
    output logic        win,
    output logic        lose
);

`ifdef SCORE_SEQ_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif
    localparam logic [3:0] MAX_LIMIT = 4'(MAX_GUESSES);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_COMPARE, S_CAPTURE, S_REPORT, S_OVER
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] code_q, code_d;
    logic [11:0] guess_q, guess_d;
    logic [1:0]  idx_q, idx_d;
    logic [2:0]  red_q, red_d;
    logic [2:0]  white_q, white_d;
    logic [3:0]  count_q, count_d;
    logic        win_q, win_d;
    logic        lose_q, lose_d;
    logic [3:0]  count_inc;
    logic        load_go;

    // Without a limit the count saturates; with one it can never exceed MAX_LIMIT.
    assign count_inc = (!LIMIT_EN && count_q == 4'hF) ? count_q : count_q + 4'd1;
    assign load_go   = code_load && (state_q == S_IDLE || state_q == S_OVER);

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        guess_d = guess_q;
        idx_d   = idx_q;
        red_d   = red_q;
        white_d = white_q;
        count_d = count_q;
        win_d   = win_q;
        lose_d  = lose_q;
        case (state_q)
            S_IDLE: begin
                if (guess_valid && !code_load) begin
                    guess_d = guess_in;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                idx_d   = 2'd0;
                state_d = S_COMPARE;
            end
            S_COMPARE: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                red_d   = cmp_red;
                white_d = cmp_white;
                state_d = S_REPORT;
            end
            S_REPORT: begin
                count_d = count_inc;
                if (red_q == 3'd4) begin
                    win_d   = 1'b1;
                    state_d = S_OVER;
                end else if (LIMIT_EN && count_inc == MAX_LIMIT) begin
                    lose_d  = 1'b1;
                    state_d = S_OVER;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_OVER:  state_d = S_OVER;
            default: state_d = S_IDLE;
        endcase
        if (load_go) begin
            code_d  = code_in;
            count_d = 4'd0;
            win_d   = 1'b0;
            lose_d  = 1'b0;
            red_d   = 3'd0;
            white_d = 3'd0;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            code_q  <= 12'd0;
            guess_q <= 12'd0;
            idx_q   <= 2'd0;
            red_q   <= 3'd0;
            white_q <= 3'd0;
            count_q <= 4'd0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            guess_q <= guess_d;
            idx_q   <= idx_d;
            red_q   <= red_d;
            white_q <= white_d;
            count_q <= count_d;
            win_q   <= win_d;
            lose_q  <= lose_d;
        end
    end

    always_comb begin
        cmp_code = code_q[2:0];
        case (idx_q)
            2'd0:    cmp_code = code_q[2:0];
            2'd1:    cmp_code = code_q[5:3];
            2'd2:    cmp_code = code_q[8:6];
            default: cmp_code = code_q[11:9];
        endcase
    end

    // Reset must clear the datapath immediately, hence the direct resetn term.
    assign cmp_resetn   = resetn && (state_q != S_CLEAR);
    assign guess_ready  = (state_q == S_IDLE);
    assign cmp_en       = (state_q == S_COMPARE);
    assign cmp_idx      = idx_q;
    assign cmp_guess    = guess_q;
    assign result_valid = (state_q == S_REPORT);
    assign score_red    = red_q;
    assign score_white  = white_q;
    assign guess_count  = count_q;
    assign win          = win_q;
    assign lose         = lose_q;

endmodule
